// File: rtl/rectangle128_cipher.sv
`default_nettype none
// =============================================================================
// rectangle128_cipher : iterative RECTANGLE-128 block cipher, one round per clock
// rev 1.0
// =============================================================================
module rectangle128_cipher (
   input  logic        Clk,
   input  logic        RstN,
   input  logic        Enable,
   input  logic [63:0] plainText,
   input  logic        Encrypt,
   input  logic [63:0] key0,
   input  logic [63:0] key1,
   output logic [63:0] cipherText,
   output logic        cipherReady
);

   localparam logic [4:0] c_KEY_LAST   = 5'd25;
   localparam logic [4:0] c_ROUND_LAST = 5'd24;
   localparam logic [4:0] c_RC_INIT    = 5'h01;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_KEYGEN = 3'd1,
      ST_ROUND  = 3'd2,
      ST_FINISH = 3'd3,
      ST_DONE   = 3'd4
   } state_t;

   state_t        state_q, state_d;
   logic [127:0]  key_q, key_d;
   logic [4:0]    rc_q, rc_d;
   logic [4:0]    cnt_q, cnt_d;
   logic [63:0]   blk_q, blk_d;
   logic          enc_q, enc_d;
   logic [63:0]   cipher_text_q, cipher_text_d;
   logic          cipher_ready_q, cipher_ready_d;
   logic [63:0]   key_store_q [0:25];
   logic          store_we;
   logic [4:0]    rk_idx;
   logic [63:0]   rk;

   function automatic logic [3:0] sbox(input logic [3:0] x);
      logic [3:0] y;
      case (x)
         4'h0: y = 4'h6;   4'h1: y = 4'h5;   4'h2: y = 4'hC;   4'h3: y = 4'hA;
         4'h4: y = 4'h1;   4'h5: y = 4'hE;   4'h6: y = 4'h7;   4'h7: y = 4'h9;
         4'h8: y = 4'hB;   4'h9: y = 4'h0;   4'hA: y = 4'h3;   4'hB: y = 4'hD;
         4'hC: y = 4'h8;   4'hD: y = 4'hF;   4'hE: y = 4'h4;   default: y = 4'h2;
      endcase
      return y;
   endfunction

   function automatic logic [3:0] inv_sbox(input logic [3:0] x);
      logic [3:0] y;
      case (x)
         4'h0: y = 4'h9;   4'h1: y = 4'h4;   4'h2: y = 4'hF;   4'h3: y = 4'hA;
         4'h4: y = 4'hE;   4'h5: y = 4'h1;   4'h6: y = 4'h0;   4'h7: y = 4'h6;
         4'h8: y = 4'hC;   4'h9: y = 4'h7;   4'hA: y = 4'h3;   4'hB: y = 4'h8;
         4'hC: y = 4'h2;   4'hD: y = 4'hB;   4'hE: y = 4'h5;   default: y = 4'hD;
      endcase
      return y;
   endfunction

   // Columns are vertical nibbles with row0 as the LSB.
   function automatic logic [63:0] sub_column(input logic [63:0] s, input logic inv);
      logic [63:0] r;
      logic [3:0]  c;
      logic [3:0]  v;
      r = '0;
      for (int j = 0; j < 16; j++) begin
         c = {s[48+j], s[32+j], s[16+j], s[j]};
         v = inv ? inv_sbox(c) : sbox(c);
         r[j]    = v[0];
         r[16+j] = v[1];
         r[32+j] = v[2];
         r[48+j] = v[3];
      end
      return r;
   endfunction

   function automatic logic [63:0] shift_row(input logic [63:0] s);
      return {s[50:48], s[63:51],
              s[35:32], s[47:36],
              s[30:16], s[31],
              s[15:0]};
   endfunction

   function automatic logic [63:0] inv_shift_row(input logic [63:0] s);
      return {s[60:48], s[63:61],
              s[43:32], s[47:44],
              s[16],    s[31:17],
              s[15:0]};
   endfunction

   function automatic logic [63:0] round_key(input logic [127:0] k);
      return {k[111:96], k[79:64], k[47:32], k[15:0]};
   endfunction

   function automatic logic [127:0] key_update(input logic [127:0] k, input logic [4:0] rc);
      logic [31:0] r0, r1, r2, r3;
      logic [3:0]  c;
      logic [3:0]  v;
      logic [127:0] n;
      {r3, r2, r1, r0} = k;
      for (int j = 0; j < 8; j++) begin
         c = {r3[j], r2[j], r1[j], r0[j]};
         v = sbox(c);
         r0[j] = v[0];
         r1[j] = v[1];
         r2[j] = v[2];
         r3[j] = v[3];
      end
      n = {{r3[15:0], r3[31:16]} ^ r0, r3, r2, {r0[23:0], r0[31:24]} ^ r1};
      n[4:0] = n[4:0] ^ rc;
      return n;
   endfunction

   function automatic logic [4:0] rc_next(input logic [4:0] rc);
      return {rc[3:0], rc[4] ^ rc[2]};
   endfunction

   // Decryption walks the key store backwards; the final whitening key sits at
   // the opposite end of the store for each direction.
   always_comb begin
      rk_idx = enc_q ? cnt_q : (c_KEY_LAST - cnt_q);
      if (state_q == ST_FINISH) begin
         rk_idx = enc_q ? c_KEY_LAST : 5'd0;
      end
   end

   assign rk = key_store_q[rk_idx];

   always_comb begin
      state_d        = state_q;
      key_d          = key_q;
      rc_d           = rc_q;
      cnt_d          = cnt_q;
      blk_d          = blk_q;
      enc_d          = enc_q;
      cipher_text_d  = cipher_text_q;
      cipher_ready_d = cipher_ready_q;
      store_we       = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (Enable) begin
               key_d   = {key1, key0};
               rc_d    = c_RC_INIT;
               cnt_d   = 5'd0;
               blk_d   = plainText;
               enc_d   = Encrypt;
               state_d = ST_KEYGEN;
            end
         end
         ST_KEYGEN: begin
            store_we = 1'b1;
            key_d    = key_update(key_q, rc_q);
            rc_d     = rc_next(rc_q);
            if (cnt_q == c_KEY_LAST) begin
               cnt_d   = 5'd0;
               state_d = ST_ROUND;
            end else begin
               cnt_d = cnt_q + 5'd1;
            end
         end
         ST_ROUND: begin
            if (enc_q) begin
               blk_d = shift_row(sub_column(blk_q ^ rk, 1'b0));
            end else begin
               blk_d = sub_column(inv_shift_row(blk_q ^ rk), 1'b1);
            end
            if (cnt_q == c_ROUND_LAST) begin
               cnt_d   = 5'd0;
               state_d = ST_FINISH;
            end else begin
               cnt_d = cnt_q + 5'd1;
            end
         end
         ST_FINISH: begin
            cipher_text_d  = blk_q ^ rk;
            cipher_ready_d = 1'b1;
            state_d        = ST_DONE;
         end
         ST_DONE: begin
            if (!Enable) begin
               cipher_ready_d = 1'b0;
               state_d        = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge Clk or negedge RstN) begin
      if (!RstN) begin
         state_q        <= ST_IDLE;
         key_q          <= '0;
         rc_q           <= '0;
         cnt_q          <= '0;
         blk_q          <= '0;
         enc_q          <= 1'b0;
         cipher_text_q  <= '0;
         cipher_ready_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         key_q          <= key_d;
         rc_q           <= rc_d;
         cnt_q          <= cnt_d;
         blk_q          <= blk_d;
         enc_q          <= enc_d;
         cipher_text_q  <= cipher_text_d;
         cipher_ready_q <= cipher_ready_d;
      end
   end

   always_ff @(posedge Clk or negedge RstN) begin
      if (!RstN) begin
         for (int i = 0; i < 26; i++) begin
            key_store_q[i] <= '0;
         end
      end else if (store_we) begin
         key_store_q[cnt_q] <= round_key(key_q);
      end
   end

   assign cipherText  = cipher_text_q;
   assign cipherReady = cipher_ready_q;

endmodule
`default_nettype wire

// File: tb/tb_rectangle128_cipher.sv
`default_nettype none
// Directed bench for rectangle128_cipher with a queue scoreboard and a
// spec-level RECTANGLE reference model.
module tb_rectangle128_cipher;

   logic        Clk = 1'b0;
   logic        RstN = 1'b0;
   logic        Enable = 1'b0;
   logic [63:0] plainText = '0;
   logic        Encrypt = 1'b0;
   logic [63:0] key0 = '0;
   logic [63:0] key1 = '0;
   logic [63:0] cipherText;
   logic        cipherReady;

   rectangle128_cipher dut (
      .Clk         (Clk),
      .RstN        (RstN),
      .Enable      (Enable),
      .plainText   (plainText),
      .Encrypt     (Encrypt),
      .key0        (key0),
      .key1        (key1),
      .cipherText  (cipherText),
      .cipherReady (cipherReady)
   );

   always #5 Clk = ~Clk;

   localparam logic [63:0] SB_TAB  = 64'h24F8D30B97E1AC56;
   localparam logic [63:0] INV_TAB = 64'hD5B2837C601EAF49;
   logic [7:0] RC_TAB [0:24] = '{8'h01, 8'h02, 8'h04, 8'h09, 8'h12, 8'h05, 8'h0B, 8'h16,
                                 8'h0C, 8'h19, 8'h13, 8'h07, 8'h0F, 8'h1F, 8'h1E, 8'h1C,
                                 8'h18, 8'h11, 8'h03, 8'h06, 8'h0D, 8'h1B, 8'h17, 8'h0E,
                                 8'h1D};

   int          tests = 0;
   int          fails = 0;
   logic [63:0] exp_q [$];
   logic [63:0] rk_m [0:25];

   function automatic logic [15:0] rotl16(input logic [15:0] x, input int n);
      logic [31:0] t;
      t = {x, x} << n;
      return t[31:16];
   endfunction

   function automatic logic [15:0] rotr16(input logic [15:0] x, input int n);
      return rotl16(x, 16 - n);
   endfunction

   function automatic logic [31:0] rotl32(input logic [31:0] x, input int n);
      logic [63:0] t;
      t = {x, x} << n;
      return t[63:32];
   endfunction

   function automatic logic [63:0] m_sub(input logic [63:0] s, input bit inv);
      logic [63:0] r;
      logic [3:0]  v;
      int          c;
      r = '0;
      for (int j = 0; j < 16; j++) begin
         c = 0;
         for (int b = 0; b < 4; b++) c = c | (int'(s[16*b+j]) << b);
         v = inv ? INV_TAB[4*c +: 4] : SB_TAB[4*c +: 4];
         for (int b = 0; b < 4; b++) r[16*b+j] = v[b];
      end
      return r;
   endfunction

   function automatic logic [63:0] m_shift(input logic [63:0] s, input bit inv);
      logic [15:0] r1, r2, r3;
      r1 = inv ? rotr16(s[31:16], 1)  : rotl16(s[31:16], 1);
      r2 = inv ? rotr16(s[47:32], 12) : rotl16(s[47:32], 12);
      r3 = inv ? rotr16(s[63:48], 13) : rotl16(s[63:48], 13);
      return {r3, r2, r1, s[15:0]};
   endfunction

   task automatic expand(input logic [127:0] key);
      logic [31:0] row [4];
      logic [31:0] t0;
      logic [3:0]  v;
      int          c;
      for (int r = 0; r < 4; r++) row[r] = key[32*r +: 32];
      for (int i = 0; i < 26; i++) begin
         rk_m[i] = {row[3][15:0], row[2][15:0], row[1][15:0], row[0][15:0]};
         if (i < 25) begin
            for (int j = 0; j < 8; j++) begin
               c = 0;
               for (int b = 0; b < 4; b++) c = c | (int'(row[b][j]) << b);
               v = SB_TAB[4*c +: 4];
               for (int b = 0; b < 4; b++) row[b][j] = v[b];
            end
            t0     = row[0];
            row[0] = rotl32(row[0], 8) ^ row[1];
            row[1] = row[2];
            row[2] = row[3];
            row[3] = rotl32(row[3], 16) ^ t0;
            row[0][4:0] = row[0][4:0] ^ RC_TAB[i][4:0];
         end
      end
   endtask

   task automatic model(input logic [63:0] pt, input logic enc, input logic [127:0] key,
                        output logic [63:0] res);
      logic [63:0] s;
      expand(key);
      s = pt;
      for (int j = 0; j < 25; j++) begin
         if (enc) s = m_shift(m_sub(s ^ rk_m[j], 0), 0);
         else     s = m_sub(m_shift(s ^ rk_m[25-j], 1), 1);
      end
      res = enc ? (s ^ rk_m[25]) : (s ^ rk_m[0]);
   endtask

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic check_ne(input string tag, input logic [63:0] got, input logic [63:0] other);
      tests++;
      assert (got !== other) else begin
         fails++;
         $error("FAIL %s: observed %h expected any value other than %h", tag, got, other);
      end
   endtask

   task automatic do_op(input string tag, input logic [63:0] pt, input logic enc,
                        input logic [127:0] key, input bit glitch, output logic [63:0] got);
      logic [63:0] m;
      int          n;
      bit          seen;
      model(pt, enc, key, m);
      exp_q.push_back(m);
      @(negedge Clk);
      plainText = pt;
      Encrypt   = enc;
      key0      = key[63:0];
      key1      = key[127:64];
      Enable    = 1'b1;
      @(posedge Clk);
      n    = 0;
      seen = 1'b0;
      while (!seen && n < 120) begin
         @(negedge Clk);
         plainText = {$urandom, $urandom};
         key0      = {$urandom, $urandom};
         key1      = {$urandom, $urandom};
         Encrypt   = ~enc;
         if (glitch) Enable = (n >= 5 && n < 46) ? ~Enable : 1'b1;
         @(posedge Clk);
         #1;
         n++;
         seen = cipherReady;
      end
      tests++;
      assert (seen && n == 52) else begin
         fails++;
         $error("FAIL %s_latency: observed %0d cycles (ready=%b) expected 52", tag, n, seen);
      end
      got = cipherText;
      check(tag, got, exp_q.pop_front());
   endtask

   task automatic release_enable(input string tag);
      @(negedge Clk);
      Enable = 1'b0;
      @(posedge Clk);
      #1;
      check(tag, {63'd0, cipherReady}, 64'd0);
   endtask

   initial begin
      logic [127:0] key_a;
      logic [127:0] key_z;
      logic [63:0]  p1;
      logic [63:0]  c1, c0, c2, c3, c4, c5, c6, d;

      key_a = {64'hAABB09182736CCDD, 64'hAABB09182736CCDD};
      key_z = '0;
      p1    = 64'h0123456789ABCDEF;

      #12;
      check("reset_text", cipherText, 64'd0);
      check("reset_ready", {63'd0, cipherReady}, 64'd0);
      @(negedge Clk);
      RstN = 1'b1;
      repeat (2) @(posedge Clk);

      do_op("enc_p1", p1, 1'b1, key_a, 1'b0, c1);
      check("store0_key_a", dut.key_store_q[0], 64'h0918CCDD0918CCDD);
      for (int i = 0; i < 20; i++) begin
         @(posedge Clk);
         #1;
         check("hold_ready", {63'd0, cipherReady}, 64'd1);
         check("hold_text", cipherText, c1);
      end
      release_enable("drop_p1");

      do_op("dec_p1", c1, 1'b0, key_a, 1'b0, d);
      check("roundtrip_p1", d, p1);
      release_enable("drop_dec_p1");

      do_op("enc_zero", 64'd0, 1'b1, key_z, 1'b0, c0);
      check("store0_key_z", dut.key_store_q[0], 64'd0);
      check("store1_key_z", dut.key_store_q[1], 64'h0000000000FF00FE);
      check_ne("enc_not_identity", c0, 64'd0);
      release_enable("drop_zero");
      do_op("dec_zero", c0, 1'b0, key_z, 1'b0, d);
      check("roundtrip_zero", d, 64'd0);
      release_enable("drop_dec_zero");

      do_op("enc_ones", '1, 1'b1, key_a, 1'b0, c2);
      release_enable("drop_ones");
      do_op("dec_ones", c2, 1'b0, key_a, 1'b0, d);
      check("roundtrip_ones", d, '1);
      release_enable("drop_dec_ones");

      do_op("enc_pt_flip", p1 ^ 64'd1, 1'b1, key_a, 1'b0, c3);
      check_ne("pt_sensitivity", c3, c1);
      release_enable("drop_pt_flip");
      do_op("enc_key_flip", p1, 1'b1, key_a ^ (128'd1 << 77), 1'b0, c4);
      check_ne("key_sensitivity", c4, c1);
      release_enable("drop_key_flip");

      do_op("enc_glitch", p1 ^ 64'hFFFF, 1'b1, key_a, 1'b1, c5);
      release_enable("drop_glitch");

      @(negedge Clk);
      plainText = p1;
      Encrypt   = 1'b1;
      key0      = key_a[63:0];
      key1      = key_a[127:64];
      Enable    = 1'b1;
      repeat (10) @(posedge Clk);
      #2;
      RstN = 1'b0;
      #1;
      check("midop_reset_text", cipherText, 64'd0);
      check("midop_reset_ready", {63'd0, cipherReady}, 64'd0);
      check("midop_reset_store0", dut.key_store_q[0], 64'd0);
      Enable = 1'b0;
      @(negedge Clk);
      RstN = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge Clk);
         #1;
         check("post_reset_idle", {63'd0, cipherReady}, 64'd0);
      end

      do_op("post_reset_enc", p1, 1'b1, key_a, 1'b0, c6);
      check("post_reset_repeat", c6, c1);
      release_enable("drop_post_reset");

      check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
